serial_tx_fifo: RTL and testbench
=================================

# serial_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO. It supports configurable data width, parity and stop-bit count, and has a flow-control block input. It sits between on-chip producers and the serial `tx` pin. It replaces the fixed 8N1 single-byte transmitter where bursts must be queued and frames sent back-to-back.

## Interface
- `CLK_PER_BIT`, 50: clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, 8: payload width; legal range 5–9.
- `PARITY`, 0: parity mode.
  - 0 = none.
  - 1 = odd: total ones in data plus parity is odd.
  - 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries; power of two, ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `data` in `DATA_BITS`: word to queue.
- `new_data` in 1: write strobe; the word is accepted when `new_data && !full`.
- `full` out 1: FIFO full; registered.
- `block` in 1: flow-control hold; registered once internally as `block_q`.
- `busy` out 1: registered; 1 when any of the following is true:
  - FIFO non-empty,
  - a frame is in progress,
  - `block_q` is high.
- `tx` out 1: serial line; registered, idle high.

## Operation
- Frame: start (0), data LSB first, optional parity bit, `STOP_BITS` stop bits (1). Each bit is held `CLK_PER_BIT` cycles.
- Frame length: `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_PER_BIT` cycles.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty and `block_q` = 0; the head word is popped into a shift register in the same cycle.
  - START → DATA after `CLK_PER_BIT` cycles.
  - DATA → PARITY, or → STOP if `PARITY` = 0, after the `DATA_BITS`-th bit.
  - PARITY → STOP after one bit time.
  - STOP ends after `STOP_BITS` bit times:
    - FIFO non-empty and `block_q` = 0: go directly to START and pop. There is no idle gap between frames.
    - Otherwise: go to IDLE.
- Parity is computed from the popped word at pop time: even = XOR of the data bits; odd = its inverse.
- Counters:
  - Bit-time counter: `$clog2(CLK_PER_BIT)` bits, cleared at every bit boundary.
  - Bit index counter: wide enough for `DATA_BITS` and `STOP_BITS`; never wraps within a frame.
- Block rules:
  - `block` never truncates a frame in flight, including its stop bits.
  - It only prevents starting a new frame.
  - Writes are still accepted while blocked.
- Full FIFO: a write with `full` = 1 is dropped silently, even if a pop occurs in the same cycle.
- Empty FIFO: the FIFO is only popped by the FSM, never externally.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `full` = 0, FIFO empty, state IDLE, `block_q` = 0.
- Reset mid-frame: the frame is abandoned, queued words are discarded, and `tx` is 1 from the next edge.
- Latency: with idle, empty, unblocked state, a write on edge k gives `tx` = 0 from edge k+2.
- `full` updates on the edge following the write that fills the last entry. It clears on the edge following the pop.
- `block` latency: a rising `block` is seen by the FSM one cycle later. A frame whose start decision falls in that cycle still starts.
- `busy` falls on the edge after the last stop-bit cycle, provided the FIFO is empty and `block_q` = 0.

## Structure
- Package `serial_pkg`:
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - state enum `tx_state_t`;
  - function `frame_bits(data_bits, parity, stop_bits)`.
- Sub-module `sync_fifo`, generic width/depth:
  - inputs: `wr_en`, `rd_en`;
  - outputs: registered `full`, `empty`, and `dout` (head word, combinational).
- The top holds the FSM, counters, shift register and parity register.

## Test plan
- Case 1 (default width and framing, `CLK_PER_BIT` = 4, 8N1):
  - Stimulus: write 0xA5.
  - Required response: `tx` low 4 cycles from edge k+2, then bits 1,0,1,0,0,1,0,1, then high. 40 cycles total; `busy` drops after.
- Case 2 (`PARITY` = 2, then `PARITY` = 1, `DATA_BITS` = 7, `STOP_BITS` = 2):
  - Stimulus: write 0x07.
  - Required response: even parity bit = 1; odd parity bit = 0. Frame is 11 bit-times.
- Case 3 (back-to-back):
  - Stimulus: write 0x01, 0x02, 0x03 on consecutive cycles.
  - Required response: three frames with no idle cycle between stop and start; 120 cycles total at `CLK_PER_BIT` = 4, 8N1.
- Case 4 (`FIFO_DEPTH` = 4, full and drop):
  - Stimulus: hold `block` = 1 and write 0x10–0x15.
  - Required response: `full` after the 4th write; 0x14 and 0x15 are dropped. Releasing `block` sends exactly 0x10–0x13, in order.
- Case 5 (block mid-frame):
  - Stimulus: raise `block` during the DATA bits of frame 1, with frame 2 queued.
  - Required response: frame 1 completes; frame 2 starts only 2 cycles after `block` falls. `busy` stays 1 throughout.
- Case 6 (reset mid-frame):
  - Stimulus: assert `rst` mid-DATA with 3 words queued.
  - Required response: next edge `tx` = 1, `busy` = 0, `full` = 0. No further frames are sent after `rst` is released.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants, state type and frame helper for the serial transmitter
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/serial_tx_fifo_sync_fifo.sv
// rtl/serial_tx_fifo_sync_fifo.sv - generic synchronous FIFO with registered full/empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             wr_ok, rd_ok;

    // A write against a full FIFO is dropped even if a pop happens in the same cycle.
    assign wr_ok = wr_en && !full_q;
    assign rd_ok = rd_en && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/serial_tx_fifo.sv
// rtl/serial_tx_fifo.sv - UART transmitter fed from an internal FIFO with flow-control hold
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = PAR_NONE,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 new_data,
    output logic                 full,
    input  logic                 block,
    output logic                 busy,
    output logic                 tx
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST      = CW'(CLK_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, fifo_dout;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d, busy_q, busy_d, block_q;
    logic                 fifo_full, fifo_empty, pop, bit_end, can_pop;

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (new_data),
        .rd_en (pop),
        .din   (data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end = (cnt_q == CNT_LAST);
    assign can_pop = !fifo_empty && !block_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (can_pop) begin
                    state_d = ST_START;
                    pop     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_STOP_LAST) begin
                        idx_d = '0;
                        // Chain straight into the next start bit so bursts have no idle gap.
                        if (can_pop) begin
                            state_d = ST_START;
                            pop     = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            shift_d = fifo_dout;
            par_d   = (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE) || !fifo_empty || block_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            block_q <= block;
        end
    end

    assign full = fifo_full;
    assign busy = busy_q;
    assign tx   = tx_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb/tb_serial_tx_fifo.sv - randomized and directed checks of serial_tx_fifo against a timeline model
module tb_serial_tx_fifo;
    import serial_pkg::*;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int FLEN  = frame_bits(DB, PAR_NONE, 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       new_data = 1'b0;
    logic       block = 1'b0;
    logic       full, busy, tx;
    logic [6:0] pdata = 7'h00;
    logic       pnew = 1'b0;
    logic       full_e, busy_e, tx_e, full_o, busy_o, tx_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data(data), .new_data(new_data), .full(full), .block(block), .busy(busy), .tx(tx));

    serial_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(2)) dut_e (
        .clk(clk), .rst(rst), .data(pdata), .new_data(pnew), .full(full_e), .block(1'b0), .busy(busy_e), .tx(tx_e));

    serial_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(2)) dut_o (
        .clk(clk), .rst(rst), .data(pdata), .new_data(pnew), .full(full_o), .block(1'b0), .busy(busy_o), .tx(tx_o));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int m);
        while (cyc < m) @(negedge clk);
    endtask

    // Frame as a list of bit values: start, data LSB first, stop.
    function automatic bit frame_bit(input int w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return w[idx-1];
        return 1'b1;
    endfunction

    // Model: FIFO as a queue, transmitter as "frame start edge + age", tx = bit[age / CPB].
    int mq[$];
    int m_word = 0, m_age = 0, m_pre = 0;
    bit m_active = 0, m_blk = 0, m_valid = 0, m_in = 0;
    bit e_tx = 1, e_busy = 0, e_full = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_blk    = 0;
            e_tx     = 1;
            e_busy   = 0;
            e_full   = 0;
            m_valid  = 1;
        end else begin
            m_in   = m_active && (m_age < FLEN);
            e_tx   = m_in ? frame_bit(m_word, m_age / CPB) : 1'b1;
            e_busy = m_in || (mq.size() != 0) || m_blk;
            m_pre  = mq.size();
            if ((!m_in || m_age == FLEN - 1) && m_pre != 0 && !m_blk) begin
                m_word   = mq.pop_front();
                m_active = 1;
                m_age    = 0;
            end else if (m_in) begin
                m_age++;
            end else begin
                m_active = 0;
            end
            if (new_data && m_pre < DEPTH) mq.push_back(int'(data));
            m_blk  = block;
            e_full = (mq.size() == DEPTH);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_tx", tx, e_tx);
            chk("model_busy", busy, e_busy);
            chk("model_full", full, e_full);
        end
    end

    task automatic rx_byte(output int w);
        int s;
        s = 0;
        w = -1;
        for (int i = 0; i < 300 && s == 0; i++) begin
            @(negedge clk);
            if (tx === 1'b0) s = cyc;
        end
        if (s == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_start_timeout: no start bit within 300 cycles at cycle %0d", cyc);
            return;
        end
        w = 0;
        for (int b = 0; b < DB; b++) begin
            at(s + CPB * (b + 1) + CPB / 2);
            w |= int'(tx) << b;
        end
        at(s + CPB * (DB + 1) + CPB / 2);
        chk("rx_stop", tx, 1);
    endtask

    task automatic quiet(input string name, input int n);
        int z;
        z = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) z++;
        end
        chk(name, z, 0);
    endtask

    initial begin
        int k;
        int w;
        logic [7:0]  lit_a5;
        logic [10:0] lit_e;
        logic [10:0] lit_o;
        lit_a5 = 8'hA5;
        lit_e  = 11'b11100001110;
        lit_o  = 11'b11000001110;

        tick();
        tick();
        rst = 1'b0;
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_full", full, 0);
        chk("reset_tx_e", tx_e, 1);

        // Case 1: single 8N1 frame of 0xA5
        data = 8'hA5; new_data = 1'b1; tick(); k = cyc; new_data = 1'b0;
        at(k + 1); chk("c1_tx_before_start", tx, 1);
        at(k + 2); chk("c1_start_first", tx, 0);
        at(k + 5); chk("c1_start_last", tx, 0);
        for (int b = 0; b < 8; b++) begin
            at(k + 2 + CPB * (b + 1) + 1);
            chk("c1_data_bit", tx, int'(lit_a5[b]));
        end
        at(k + 41); chk("c1_stop", tx, 1); chk("c1_busy_in_stop", busy, 1);
        at(k + 42); chk("c1_busy_after", busy, 0);

        // Case 2: 7 data bits, 2 stop bits, even and odd parity
        pdata = 7'h07; pnew = 1'b1; tick(); k = cyc; pnew = 1'b0;
        for (int b = 0; b < 11; b++) begin
            at(k + 2 + CPB * b + 2);
            chk("c2_even_bit", tx_e, int'(lit_e[b]));
            chk("c2_odd_bit", tx_o, int'(lit_o[b]));
        end
        at(k + 45); chk("c2_busy_last_stop", busy_e, 1);
        at(k + 46); chk("c2_busy_e_after", busy_e, 0); chk("c2_busy_o_after", busy_o, 0);
        chk("c2_full_e", full_e, 0); chk("c2_full_o", full_o, 0);

        // Case 3: back-to-back frames
        data = 8'h01; new_data = 1'b1; tick(); k = cyc;
        data = 8'h02; tick();
        data = 8'h03; tick();
        new_data = 1'b0;
        at(k + 41);  chk("c3_f1_stop", tx, 1);
        at(k + 42);  chk("c3_f2_start", tx, 0);
        at(k + 81);  chk("c3_f2_stop", tx, 1);
        at(k + 82);  chk("c3_f3_start", tx, 0);
        at(k + 121); chk("c3_f3_stop", tx, 1); chk("c3_busy_end", busy, 1);
        at(k + 122); chk("c3_busy_after", busy, 0);

        // Case 4: fill while blocked, overflow writes dropped
        block = 1'b1; tick();
        for (int i = 0; i < 6; i++) begin
            data = 8'(8'h10 + i); new_data = 1'b1; tick();
            chk("c4_full", full, (i >= 3) ? 1 : 0);
        end
        new_data = 1'b0;
        quiet("c4_blocked_quiet", 20);
        block = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_byte(w);
            chk("c4_word", w, 16 + i);
        end
        quiet("c4_no_extra", 60);
        chk("c4_busy_idle", busy, 0);

        // Case 5: block raised mid-frame with a second frame queued
        data = 8'h3C; new_data = 1'b1; tick(); k = cyc;
        data = 8'hC3; tick();
        new_data = 1'b0;
        at(k + 14); block = 1'b1;
        at(k + 41); chk("c5_f1_stop", tx, 1);
        for (int m = k + 42; m <= k + 60; m++) begin
            at(m);
            chk("c5_hold_tx", tx, 1);
            chk("c5_hold_busy", busy, 1);
        end
        block = 1'b0;
        at(k + 62); chk("c5_still_idle", tx, 1);
        at(k + 63); chk("c5_f2_start", tx, 0);
        at(k + 104);
        quiet("c5_done", 20);

        // Case 6: reset mid-frame with words queued
        data = 8'h55; new_data = 1'b1; tick(); k = cyc;
        data = 8'h66; tick();
        data = 8'h77; tick();
        new_data = 1'b0;
        at(k + 18);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("c6_tx", tx, 1);
        chk("c6_busy", busy, 0);
        chk("c6_full", full, 0);
        quiet("c6_no_frames", 60);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            new_data = (($urandom % 3) == 0);
            data     = 8'($urandom);
            if (($urandom % 50) == 0) block = ~block;
            tick();
        end
        new_data = 1'b0;
        block    = 1'b0;
        repeat (300) tick();
        @(negedge clk);
        chk("rand_drained_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
